// File: rtl/num_bit_pkg.sv
// Shared constants for the num_bit population-count block.
// Default geometry and the minimum count-width helper.
package num_bit_pkg;

  localparam int WIDTH_D   = 8;
  localparam int COUNT_W_D = 8;

  function automatic int min_count_w(
    input int w
  );
    return $clog2(w + 1);
  endfunction

  localparam int MIN_COUNT_W_D =
    min_count_w(WIDTH_D);

endpackage

// File: rtl/num_bit_popcount.sv
// Combinational balanced adder-tree popcount.
// Returns the number of set bits in i_signal.
module num_bit_popcount
  import num_bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CW    = min_count_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_signal,
  output logic [CW-1:0]    o_pop
);

  localparam int LV = (WIDTH > 1) ?
    $clog2(WIDTH) : 0;
  localparam int N  = 1 << LV;

  // Heap layout: node k sums nodes 2k and 2k+1.
  logic [CW-1:0] w_node [1:2*N-1];

  for (genvar k = N; k < 2*N; k++) begin : g_leaf
    if (k - N < WIDTH) begin : g_bit
      assign w_node[k] = CW'(i_signal[k-N]);
    end else begin : g_pad
      assign w_node[k] = '0;
    end
  end

  for (genvar k = 1; k < N; k++) begin : g_sum
    assign w_node[k] =
      w_node[2*k] + w_node[2*k+1];
  end

  assign o_pop = w_node[1];

endmodule

// File: rtl/num_bit.sv
// Registered ones/zeros count of an input word.
// Result appears one clock after a valid input.
module num_bit
  import num_bit_pkg::*;
#(
  parameter int WIDTH   = WIDTH_D,
  parameter int COUNT_W = COUNT_W_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   signal,
  input  logic               ones,
  input  logic               in_valid,
  output logic [COUNT_W-1:0] count,
  output logic               out_valid
);

  localparam int CW = min_count_w(WIDTH);

  if (COUNT_W < CW) begin : g_chk
    $error("COUNT_W too narrow for WIDTH");
  end

  logic [CW-1:0]      w_pop;
  logic [CW-1:0]      w_res;
  logic [COUNT_W-1:0] r_count;
  logic               r_valid;

  num_bit_popcount #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_pop (
    .i_signal (signal),
    .o_pop    (w_pop)
  );

  assign w_res = ones ? w_pop :
    CW'(WIDTH) - w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_count <= COUNT_W'(w_res);
      end
    end
  end

  assign count     = r_count;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_num_bit.sv
// Self-checking bench for num_bit.
// Directed and random steps against a count model.
module tb_num_bit;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  signal;
  logic          ones;
  logic          in_valid;
  logic [CW-1:0] count;
  logic          out_valid;

  int n_checks;
  int n_errors;
  int exp_count;
  int exp_valid;
  int c0;

  num_bit #(
    .WIDTH   (W),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .signal    (signal),
    .ones      (ones),
    .in_valid  (in_valid),
    .count     (count),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_cnt(
    input logic [W-1:0] s,
    input logic         o
  );
    int p;
    p = $countones(s);
    return o ? p : W - p;
  endfunction

  task automatic check(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d",
        tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, ".count"}, int'(count),
      exp_count);
    check({tag, ".valid"}, int'(out_valid),
      exp_valid);
  endtask

  task automatic step(
    input logic [W-1:0] s,
    input logic         o,
    input logic         v,
    input string        tag
  );
    signal   = s;
    ones     = o;
    in_valid = v;
    @(posedge clk);
    #1;
    exp_valid = v ? 1 : 0;
    if (v) exp_count = ref_cnt(s, o);
    check_out(tag);
  endtask

  logic [W-1:0] tsig [7];
  logic         tone [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    tsig = '{8'h00, 8'h00, 8'hFF, 8'hFF,
             8'hA5, 8'h01, 8'hFE};
    tone = '{1'b1, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b1};

    rst_n    = 1'b0;
    signal   = 8'hFF;
    ones     = 1'b1;
    in_valid = 1'b1;
    exp_count = 0;
    exp_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      step(tsig[i], tone[i], 1'b1, "directed");
    step(8'hA5, 1'b0, 1'b1, "a5_zeros");
    step(8'h01, 1'b1, 1'b1, "01_ones");

    for (int w = 0; w < 256; w++) begin
      step(W'(w), 1'b0, 1'b1, "sweep0");
      c0 = int'(count);
      step(W'(w), 1'b1, 1'b1, "sweep1");
      check("sweep_sum", c0 + int'(count), W);
    end

    for (int i = 0; i < 300; i++)
      step(W'($urandom), 1'($urandom),
        1'($urandom_range(0, 3) != 0),
        "random");

    step(8'h0F, 1'b1, 1'b1, "gap_first");
    check("gap_first_val", int'(count), 4);
    for (int i = 0; i < 3; i++)
      step(W'($urandom), 1'($urandom),
        1'b0, "gap_idle");
    check("gap_hold_val", int'(count), 4);
    step(8'h0F, 1'b0, 1'b1, "gap_second");
    check("gap_second_val", int'(count), 4);

    step(8'hFF, 1'b1, 1'b1, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    exp_valid = 0;
    check_out("async_clear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_out("async_after");

    step(8'h03, 1'b1, 1'b1, "mid_a");
    signal   = 8'h7F;
    ones     = 1'b1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_count = 0;
    exp_valid = 0;
    check_out("mid_reset");
    rst_n = 1'b1;
    step(8'h7F, 1'b1, 1'b0, "mid_idle");
    step(8'h3C, 1'b0, 1'b1, "mid_post");
    step(8'h3C, 1'b1, 1'b0, "mid_tail");

    $display("CHECKS %0d ERRORS %0d",
      n_checks, n_errors);
    $finish;
  end

endmodule
